// File: rtl/gpc_acc_pkg.sv
// Shared helpers for the GPC sum accumulator: width derivation and lane slicing.
package gpc_acc_pkg;

  // Widest lane bus the slicing helper accepts; narrower buses are zero-extended.
  localparam int LANE_BUS_W = 256;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int acc_width(input int in_w, input int lanes, input int frame_len);
    return in_w + clog2(lanes) + clog2(frame_len);
  endfunction

  function automatic int cnt_width(input int frame_len);
    return clog2(frame_len) + 1;
  endfunction

  function automatic logic [31:0] lane(input logic [LANE_BUS_W-1:0] data, input int i,
                                       input int w);
    return 32'(data >> (i * w)) & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/gpc_lane_adder.sv
// Combinational unsigned adder over all lanes of one beat; may later be replaced by a GPC tree.
module gpc_lane_adder
  import gpc_acc_pkg::*;
#(
  parameter int LANES = 4,
  parameter int IN_W  = 5,
  parameter int SUM_W = IN_W + clog2(LANES)
) (
  input  logic [LANES*IN_W-1:0] data,
  output logic [SUM_W-1:0]      sum
);

  logic [LANE_BUS_W-1:0] bus;

  always_comb begin
    bus = LANE_BUS_W'(data);
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + SUM_W'(lane(bus, i, IN_W));
    end
  end

endmodule

// File: rtl/gpc_sum_accumulator.sv
// Sums the lanes of each beat, accumulates beats into a frame total and emits one
// held result per frame over valid/ready handshakes.
module gpc_sum_accumulator
  import gpc_acc_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int IN_W      = 5,
  parameter int FRAME_LEN = 8,
  parameter int ACC_W     = acc_width(IN_W, LANES, FRAME_LEN),
  parameter int CNT_W     = cnt_width(FRAME_LEN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*IN_W-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_sum,
  output logic [CNT_W-1:0]      out_beats
);

  localparam int SUM_W = IN_W + clog2(LANES);

  logic [SUM_W-1:0] lane_sum;
  logic             accept;
  logic             beat_is_last;
  logic             drain_p1;

  logic             vld_p1;
  logic             last_p1;
  logic [SUM_W-1:0] lane_sum_p1;
  logic [CNT_W-1:0] beat_no_p1;

  logic [CNT_W-1:0] beat_cnt;
  logic [ACC_W-1:0] acc;

  gpc_lane_adder #(
    .LANES (LANES),
    .IN_W  (IN_W),
    .SUM_W (SUM_W)
  ) u_lane_adder (
    .data (in_data),
    .sum  (lane_sum)
  );

  // A last beat may only leave S1 when the output register is free or being emptied.
  assign drain_p1     = vld_p1 & (~last_p1 | ~out_valid | out_ready);
  assign in_ready     = rst_n & (~vld_p1 | drain_p1);
  assign accept       = in_valid & in_ready;
  assign beat_is_last = in_last | (beat_cnt == CNT_W'(FRAME_LEN - 1));

  // ---- stage 0 -> stage 1: lane sum and frame bookkeeping ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      beat_cnt <= '0;
    end else if (accept) begin
      vld_p1   <= 1'b1;
      last_p1  <= beat_is_last;
      beat_cnt <= beat_is_last ? '0 : beat_cnt + CNT_W'(1);
    end else if (drain_p1) begin
      vld_p1   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lane_sum_p1 <= lane_sum;
      beat_no_p1  <= beat_cnt;
    end
  end

  // ---- stage 1 -> output: accumulate and close the frame ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_beats <= '0;
    end else begin
      if (drain_p1) begin
        acc <= last_p1 ? '0 : acc + ACC_W'(lane_sum_p1);
      end
      if (drain_p1 && last_p1) begin
        out_valid <= 1'b1;
        out_sum   <= acc + ACC_W'(lane_sum_p1);
        out_beats <= beat_no_p1 + CNT_W'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gpc_sum_accumulator.sv
// Directed self-checking bench for gpc_sum_accumulator with default parameters.
module tb_gpc_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [19:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [9:0]  out_sum;
  logic [3:0]  out_beats;

  int checks = 0;
  int passed = 0;
  int stall_cnt = 0;
  int q_sum[$];
  int q_beats[$];

  localparam logic [19:0] ALL31 = 20'hFFFFF;
  localparam logic [19:0] L1234 = {5'd4, 5'd3, 5'd2, 5'd1};
  localparam logic [19:0] L1111 = {5'd1, 5'd1, 5'd1, 5'd1};
  // compressor result 0x0f (src0=1, src1=2, src2=0x2d) on lane 0, other lanes 0
  localparam logic [19:0] LGPC  = {15'd0, 5'h0f};

  gpc_sum_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_beats (out_beats)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so the negedge sees what the next edge will use.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      q_sum.push_back(int'(out_sum));
      q_beats.push_back(int'(out_beats));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [19:0] d, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    #1;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    stall_cnt += n;
    if (!in_ready) begin
      checks++;
      $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%0b exp=0", out_valid); else passed++;
    checks++; if (out_sum !== 10'd0) $display("FAIL rst_out_sum got=%0d exp=0", out_sum); else passed++;
    checks++; if (out_beats !== 4'd0) $display("FAIL rst_out_beats got=%0d exp=0", out_beats); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready_low got=%0b exp=0", in_ready); else passed++;
    @(posedge clk); #1; rst_n = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready_idle got=%0b exp=1", in_ready); else passed++;
    tick();
  endtask

  task automatic test_full_frame();
    q_sum.delete(); q_beats.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(ALL31, 1'b0);
    checks++; if (out_valid !== 1'b0) $display("FAIL full_latency_early got=%0b exp=0", out_valid); else passed++;
    tick();
    checks++; if (out_valid !== 1'b1) $display("FAIL full_valid got=%0b exp=1", out_valid); else passed++;
    checks++; if (out_sum !== 10'd992) $display("FAIL full_sum got=%0d exp=992", out_sum); else passed++;
    checks++; if (out_beats !== 4'd8) $display("FAIL full_beats got=%0d exp=8", out_beats); else passed++;
    tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL full_pulse got=%0b exp=0", out_valid); else passed++;
    checks++; if (q_sum.size() !== 1) $display("FAIL full_count got=%0d exp=1", q_sum.size()); else passed++;
  endtask

  task automatic test_early_close();
    q_sum.delete(); q_beats.delete();
    out_ready = 1'b1;
    send(L1234, 1'b0);
    send(L1234, 1'b0);
    send(L1234, 1'b1);
    tick(); tick();
    checks++;
    if (q_sum.size() !== 1) $display("FAIL early_count got=%0d exp=1", q_sum.size());
    else begin
      if (q_sum[0] !== 30 || q_beats[0] !== 3)
        $display("FAIL early_result got=%0d/%0d exp=30/3", q_sum[0], q_beats[0]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    q_sum.delete(); q_beats.delete();
    out_ready = 1'b1;
    stall_cnt = 0;
    for (int i = 0; i < 8; i++) send(ALL31, 1'b0);
    for (int i = 0; i < 3; i++) send(L1234, i == 2);
    checks++; if (stall_cnt !== 0) $display("FAIL b2b_stalls got=%0d exp=0", stall_cnt); else passed++;
    tick(); tick();
    checks++;
    if (q_sum.size() !== 2) $display("FAIL b2b_count got=%0d exp=2", q_sum.size());
    else begin
      if (q_sum[0] !== 992 || q_beats[0] !== 8 || q_sum[1] !== 30 || q_beats[1] !== 3)
        $display("FAIL b2b_results got=%0d/%0d,%0d/%0d exp=992/8,30/3",
                 q_sum[0], q_beats[0], q_sum[1], q_beats[1]);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    q_sum.delete(); q_beats.delete();
    out_ready = 1'b0;
    send(L1234, 1'b0);
    send(L1234, 1'b1);
    for (int i = 0; i < 3; i++) send(ALL31, i == 2);
    #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got=%0b exp=0", in_ready); else passed++;
    checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid got=%0b exp=1", out_valid); else passed++;
    tick(); tick();
    checks++; if (out_sum !== 10'd20 || out_beats !== 4'd2)
      $display("FAIL bp_hold got=%0d/%0d exp=20/2", out_sum, out_beats); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_hold got=%0b exp=0", in_ready); else passed++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_sum !== 10'd372 || out_beats !== 4'd3)
      $display("FAIL bp_second got=%0b/%0d/%0d exp=1/372/3", out_valid, out_sum, out_beats); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL bp_release got=%0b exp=1", in_ready); else passed++;
    out_ready = 1'b1;
    tick(); tick();
    checks++;
    if (q_sum.size() !== 2) $display("FAIL bp_count got=%0d exp=2", q_sum.size());
    else begin
      if (q_sum[0] !== 20 || q_beats[0] !== 2 || q_sum[1] !== 372 || q_beats[1] !== 3)
        $display("FAIL bp_order got=%0d/%0d,%0d/%0d exp=20/2,372/3",
                 q_sum[0], q_beats[0], q_sum[1], q_beats[1]);
      else passed++;
    end
    checks++; if (out_valid !== 1'b0) $display("FAIL bp_empty got=%0b exp=0", out_valid); else passed++;
  endtask

  task automatic test_gpc_vectors();
    int model;
    q_sum.delete(); q_beats.delete();
    out_ready = 1'b1;
    model = 0;
    for (int i = 0; i < 8; i++) begin
      send(LGPC, 1'b0);
      model += 15;
    end
    tick(); tick();
    checks++;
    if (q_sum.size() !== 1) $display("FAIL gpc_count got=%0d exp=1", q_sum.size());
    else begin
      if (q_sum[0] !== model || q_sum[0] !== 120 || q_beats[0] !== 8)
        $display("FAIL gpc_sum got=%0d/%0d exp=%0d/8", q_sum[0], q_beats[0], model);
      else passed++;
    end
  endtask

  task automatic test_reset_midframe();
    q_sum.delete(); q_beats.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(ALL31, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_sum !== 10'd0 || out_beats !== 4'd0)
      $display("FAIL midrst_outputs got=%0b/%0d/%0d exp=0/0/0", out_valid, out_sum, out_beats); else passed++;
    @(posedge clk); #1; rst_n = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL midrst_ready got=%0b exp=1", in_ready); else passed++;
    tick();
    checks++; if (q_sum.size() !== 0) $display("FAIL midrst_no_output got=%0d exp=0", q_sum.size()); else passed++;
    for (int i = 0; i < 8; i++) send(L1111, 1'b0);
    tick();
    checks++; if (out_valid !== 1'b1 || out_sum !== 10'd32 || out_beats !== 4'd8)
      $display("FAIL midrst_next got=%0b/%0d/%0d exp=1/32/8", out_valid, out_sum, out_beats); else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_early_close();
    test_back_to_back();
    test_backpressure();
    test_gpc_vectors();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
